// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit/RTS, byte transmit on the
// device clock, line-ACK check, response receive with 0xFE resend retries.
module ps2_host_cmd_ctrl #(
  parameter int unsigned INHIBIT_CYC = 2500,
  parameter int unsigned TIMEOUT_CYC = 375000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       clk25,
  input  logic       clr,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       host_busy,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] resp_data
);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, RESP, DONE} state_t;
  state_t state, state_nx;

  logic [7:0]  c_sh, d_sh;
  logic        c_filt, d_filt, c_filt_q;
  logic [31:0] cnt;
  logic [31:0] retry_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  tx_byte;
  logic        tx_par;
  logic        d_drv;
  logic [9:0]  rx_sh;

  logic        fall, last_fall, timeout, frame_ok, retry;
  logic [10:0] frame;

  // Frame as it stands including the bit sampled on the current fall.
  assign fall      = c_filt_q & ~c_filt;
  assign last_fall = fall && (bit_cnt == 4'd10);
  assign frame     = {d_filt, rx_sh};
  assign frame_ok  = ~frame[0] & frame[10] & (^frame[9:1]);
  assign timeout   = ~fall && (cnt == TIMEOUT_CYC - 1);
  assign retry     = frame_ok && (frame[8:1] == 8'hFE) && (retry_cnt < MAX_RETRY);

  always_ff @(posedge clk25) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nx = INHIBIT;
      INHIBIT: if (cnt == INHIBIT_CYC - 1) state_nx = RTS;
      RTS:     state_nx = SEND;
      SEND:    if (last_fall)    state_nx = d_filt ? DONE : RESP;
               else if (timeout) state_nx = DONE;
      RESP:    if (last_fall)    state_nx = retry ? INHIBIT : DONE;
               else if (timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    host_busy = (state != IDLE);
    ps2c_oe   = (state == INHIBIT) || (state == RTS);
    ps2d_oe   = (state == RTS) || ((state == SEND) && d_drv);
    done      = (state == DONE);
  end

  always_ff @(posedge clk25) begin
    if (clr) begin
      c_sh      <= '1;
      d_sh      <= '1;
      c_filt    <= 1'b1;
      d_filt    <= 1'b1;
      c_filt_q  <= 1'b1;
      cnt       <= '0;
      retry_cnt <= '0;
      bit_cnt   <= '0;
      tx_byte   <= '0;
      tx_par    <= 1'b0;
      d_drv     <= 1'b0;
      rx_sh     <= '0;
      status    <= '0;
      resp_data <= '0;
    end else begin
      c_sh     <= {c_sh[6:0], ps2c_in};
      d_sh     <= {d_sh[6:0], ps2d_in};
      if (&c_sh)       c_filt <= 1'b1;
      else if (~|c_sh) c_filt <= 1'b0;
      if (&d_sh)       d_filt <= 1'b1;
      else if (~|d_sh) d_filt <= 1'b0;
      c_filt_q <= c_filt;

      unique case (state)
        IDLE: if (cmd_valid) begin
          tx_byte   <= cmd_data;
          tx_par    <= ~^cmd_data;
          retry_cnt <= '0;
          cnt       <= '0;
        end
        INHIBIT: cnt <= (cnt == INHIBIT_CYC - 1) ? '0 : cnt + 32'd1;
        RTS: begin
          cnt     <= '0;
          bit_cnt <= '0;
          d_drv   <= 1'b1;
        end
        SEND: if (fall) begin
          cnt     <= '0;
          bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
          if (bit_cnt < 4'd8)       d_drv <= ~tx_byte[bit_cnt[2:0]];
          else if (bit_cnt == 4'd8) d_drv <= ~tx_par;
          else                      d_drv <= 1'b0;
          if (last_fall && d_filt) status <= 2'b01;
        end else begin
          cnt <= cnt + 32'd1;
          if (timeout) status <= 2'b01;
        end
        RESP: if (fall) begin
          cnt     <= '0;
          rx_sh   <= frame[10:1];
          bit_cnt <= bit_cnt + 4'd1;
          if (last_fall) begin
            bit_cnt   <= '0;
            resp_data <= frame[8:1];
            if (!frame_ok)                status    <= 2'b10;
            else if (retry)               retry_cnt <= retry_cnt + 32'd1;
            else if (frame[8:1] == 8'hFE) status    <= 2'b11;
            else                          status    <= 2'b00;
          end
        end else begin
          cnt <= cnt + 32'd1;
          if (timeout) status <= 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: open-drain PS/2 device model, response
// scoreboard derived from the retry/status rules, bus-phase monitor.
module tb_ps2_host_cmd_ctrl;
  localparam int INH = 2500;
  localparam int TO  = 3000;
  localparam int MR  = 2;
  localparam int H   = 25;

  logic       clk25 = 1'b0;
  logic       clr, cmd_valid, cmd_ready;
  logic [7:0] cmd_data;
  logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  logic       host_busy, done;
  logic [1:0] status;
  logic [7:0] resp_data;
  logic       dev_clk, dev_data;

  int total = 0;
  int bad   = 0;

  // Wired-AND open-drain pins with pull-ups.
  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_data & ~ps2d_oe;

  always #20 clk25 = ~clk25;

  ps2_host_cmd_ctrl #(
    .INHIBIT_CYC(INH),
    .TIMEOUT_CYC(TO),
    .MAX_RETRY  (MR)
  ) dut (
    .clk25    (clk25),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .host_busy(host_busy),
    .done     (done),
    .status   (status),
    .resp_data(resp_data)
  );

  // Bus monitor: inhibit run lengths, done pulses, RTS overlap length.
  int         done_cnt = 0, dbl_done = 0, overlap_bad = 0, inh_run = 0, both_run = 0;
  int         inh_q[$];
  logic       prev_done = 1'b0;
  logic [1:0] st_done  = 2'b00;
  logic [7:0] rsp_done = 8'h00;
  logic [1:0] oe_done  = 2'b00;

  always @(posedge clk25) begin
    #1;
    if (ps2c_oe === 1'b1 && ps2d_oe === 1'b0) inh_run++;
    else if (inh_run != 0) begin inh_q.push_back(inh_run); inh_run = 0; end
    if (ps2c_oe === 1'b1 && ps2d_oe === 1'b1) both_run++;
    else both_run = 0;
    if (both_run > 1) overlap_bad++;
    if (done === 1'b1) begin
      done_cnt++;
      st_done  = status;
      rsp_done = resp_data;
      oe_done  = {ps2c_oe, ps2d_oe};
      if (prev_done === 1'b1) dbl_done++;
    end
    prev_done = done;
  end

  logic [7:0] rsp_q[$];
  bit         badp_q[$];
  logic [7:0] last_resp = 8'h00;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk25); #1; end
  endtask

  // Expected outcome from the resend rules: attempts, status, final response.
  function automatic void model(output int att, output logic [1:0] st, output logic [7:0] rs);
    att = 0; st = 2'b00; rs = 8'h00;
    for (int i = 0; i < rsp_q.size(); i++) begin
      att = i + 1;
      rs  = rsp_q[i];
      if (badp_q[i]) begin st = 2'b10; return; end
      if (rsp_q[i] != 8'hFE) begin st = 2'b00; return; end
      if (i >= MR) begin st = 2'b11; return; end
    end
  endfunction

  task automatic wait_send(output bit ok);
    int n;
    n = 0;
    while (!(ps2d_oe === 1'b1 && ps2c_oe === 1'b0) && n < 4 * INH) begin cyc(1); n++; end
    ok = (n < 4 * INH);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badp);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badp, b, 1'b0};
    cyc(H);
    for (int i = 0; i < 11; i++) begin
      dev_data = f[i]; cyc(H); dev_clk = 1'b0; cyc(H); dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic run_attempt(input logic [7:0] rsp, input bit badp, output logic [7:0] seen,
                             output logic par, output logic stp, output bit ok);
    seen = 8'h00; par = 1'b0; stp = 1'b0;
    wait_send(ok);
    if (!ok) return;
    for (int k = 1; k <= 10; k++) begin
      cyc(H); dev_clk = 1'b0; cyc(H - 2);
      if (k <= 8)      seen[k-1] = ps2d_in;
      else if (k == 9) par = ps2d_in;
      else             stp = ps2d_in;
      cyc(2); dev_clk = 1'b1;
    end
    dev_data = 1'b0; cyc(H); dev_clk = 1'b0; cyc(H); dev_clk = 1'b1; dev_data = 1'b1;
    send_frame(rsp, badp);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] cmd);
    int att, d0, n;
    logic [1:0] est;
    logic [7:0] ersp, seen;
    logic par, stp;
    bit ok;
    model(att, est, ersp);
    d0 = done_cnt;
    inh_q.delete();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle: got %b want 1", tag, cmd_ready); end
    cmd_data = cmd; cmd_valid = 1'b1; cyc(1); cmd_valid = 1'b0; cmd_data = 8'($urandom);
    total++; if (host_busy !== 1'b1 || cmd_ready !== 1'b0)
      begin bad++; $display("FAIL %s busy_after_accept: got busy=%b ready=%b want 1/0", tag, host_busy, cmd_ready); end
    for (int a = 0; a < att; a++) begin
      run_attempt(rsp_q[a], badp_q[a], seen, par, stp, ok);
      total++; if (!ok) begin bad++; $display("FAIL %s send_start a%0d: no RTS release within bound", tag, a); break; end
      total++; if (seen !== cmd) begin bad++; $display("FAIL %s data_bits a%0d: got %h want %h", tag, a, seen, cmd); end
      total++; if (par !== ~^cmd) begin bad++; $display("FAIL %s parity_bit a%0d: got %b want %b", tag, a, par, ~^cmd); end
      total++; if (stp !== 1'b1) begin bad++; $display("FAIL %s stop_bit a%0d: got %b want 1", tag, a, stp); end
    end
    n = 0;
    while (done_cnt == d0 && n < 400) begin cyc(1); n++; end
    cyc(20);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL %s done_count: got %0d want 1", tag, done_cnt - d0); end
    total++; if (st_done !== est) begin bad++; $display("FAIL %s status: got %b want %b", tag, st_done, est); end
    total++; if (rsp_done !== ersp) begin bad++; $display("FAIL %s resp_data: got %h want %h", tag, rsp_done, ersp); end
    total++; if (oe_done !== 2'b00) begin bad++; $display("FAIL %s oe_at_done: got %b want 00", tag, oe_done); end
    total++; if (inh_q.size() != att) begin bad++; $display("FAIL %s inhibit_phases: got %0d want %0d", tag, inh_q.size(), att); end
    foreach (inh_q[i]) begin
      total++; if (inh_q[i] != INH) begin bad++; $display("FAIL %s inhibit_len %0d: got %0d want %0d", tag, i, inh_q[i], INH); end
    end
    total++; if (dbl_done != 0 || overlap_bad != 0)
      begin bad++; $display("FAIL %s pulse_shape: got dbl_done=%0d overlap=%0d want 0/0", tag, dbl_done, overlap_bad); end
    total++; if (cmd_ready !== 1'b1 || host_busy !== 1'b0)
      begin bad++; $display("FAIL %s idle_after: got ready=%b busy=%b want 1/0", tag, cmd_ready, host_busy); end
    last_resp = ersp;
  endtask

  task automatic test_reset();
    clr = 1'b1; cmd_valid = 1'b1; cmd_data = 8'hED; cyc(3);
    total++; if (cmd_ready !== 1'b1 || host_busy !== 1'b0)
      begin bad++; $display("FAIL reset_idle: got ready=%b busy=%b want 1/0", cmd_ready, host_busy); end
    total++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0)
      begin bad++; $display("FAIL reset_oe: got %b%b want 00", ps2c_oe, ps2d_oe); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (status !== 2'b00 || resp_data !== 8'h00)
      begin bad++; $display("FAIL reset_regs: got status=%b resp=%h want 00/00", status, resp_data); end
    clr = 1'b0; cmd_valid = 1'b0; cyc(10);
    total++; if (host_busy !== 1'b0 || ps2c_oe !== 1'b0)
      begin bad++; $display("FAIL reset_clr_wins: got busy=%b c_oe=%b want 0/0", host_busy, ps2c_oe); end
  endtask

  task automatic test_basic();
    rsp_q = '{8'hFA}; badp_q = '{1'b0};
    run_txn("basic_ED", 8'hED);
  endtask

  task automatic test_resend_once();
    rsp_q = '{8'hFE, 8'hFA}; badp_q = '{1'b0, 1'b0};
    run_txn("resend_once", 8'hED);
  endtask

  task automatic test_retry_exhausted();
    rsp_q = '{8'hFE, 8'hFE, 8'hFE}; badp_q = '{1'b0, 1'b0, 1'b0};
    run_txn("retry_exhausted", 8'hF3);
  endtask

  task automatic test_parity_err();
    rsp_q = '{8'hFA}; badp_q = '{1'b1};
    run_txn("resp_parity", 8'hED);
  endtask

  task automatic test_timeout();
    int n, d0;
    bit ok;
    d0 = done_cnt;
    cmd_data = 8'hFF; cmd_valid = 1'b1; cyc(1); cmd_valid = 1'b0;
    wait_send(ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_rts: no RTS release within bound"); end
    n = 0;
    while (done !== 1'b1 && n < TO + 100) begin cyc(1); n++; end
    // Done arrives TIMEOUT_CYC+1 cycles after the RTS cycle.
    total++; if (n + 1 < TO || n + 1 > TO + 2)
      begin bad++; $display("FAIL timeout_latency: got %0d want %0d", n + 1, TO + 1); end
    total++; if (status !== 2'b01) begin bad++; $display("FAIL timeout_status: got %b want 01", status); end
    total++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0)
      begin bad++; $display("FAIL timeout_oe: got %b%b want 00", ps2c_oe, ps2d_oe); end
    total++; if (resp_data !== last_resp)
      begin bad++; $display("FAIL timeout_resp_hold: got %h want %h", resp_data, last_resp); end
    cyc(5);
    total++; if (done_cnt - d0 != 1 || cmd_ready !== 1'b1)
      begin bad++; $display("FAIL timeout_end: got dones=%0d ready=%b want 1/1", done_cnt - d0, cmd_ready); end
  endtask

  task automatic test_clr_mid();
    int d0;
    bit ok;
    cmd_data = 8'($urandom); cmd_valid = 1'b1; cyc(1); cmd_valid = 1'b0;
    wait_send(ok);
    total++; if (!ok) begin bad++; $display("FAIL clr_mid_rts: no RTS release within bound"); end
    for (int k = 1; k <= 3; k++) begin cyc(H); dev_clk = 1'b0; cyc(H); dev_clk = 1'b1; end
    cyc(H); dev_clk = 1'b0; cyc(H - 2);
    d0 = done_cnt;
    clr = 1'b1; cyc(1); clr = 1'b0;
    total++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0)
      begin bad++; $display("FAIL clr_mid_oe: got %b%b want 00", ps2c_oe, ps2d_oe); end
    total++; if (cmd_ready !== 1'b1 || host_busy !== 1'b0)
      begin bad++; $display("FAIL clr_mid_idle: got ready=%b busy=%b want 1/0", cmd_ready, host_busy); end
    total++; if (status !== 2'b00 || resp_data !== 8'h00)
      begin bad++; $display("FAIL clr_mid_regs: got status=%b resp=%h want 00/00", status, resp_data); end
    dev_clk = 1'b1;
    cyc(60);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL clr_mid_no_done: got %0d dones want 0", done_cnt - d0); end
    last_resp = 8'h00;
    rsp_q = '{8'hFA}; badp_q = '{1'b0};
    run_txn("after_clr_FF", 8'hFF);
  endtask

  task automatic test_random();
    int sel;
    for (int it = 0; it < 4; it++) begin
      rsp_q.delete(); badp_q.delete();
      for (int j = 0; j <= MR; j++) begin
        sel = $urandom_range(0, 2);
        rsp_q.push_back(sel == 0 ? 8'hFE : (sel == 1 ? 8'hFA : 8'($urandom)));
        badp_q.push_back($urandom_range(0, 7) == 0);
      end
      run_txn($sformatf("random%0d", it), 8'($urandom));
    end
  endtask

  initial begin
    clr = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    test_reset();
    test_basic();
    test_resend_once();
    test_retry_exhausted();
    test_timeout();
    test_parity_err();
    test_clr_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

endmodule
